// File: rtl/mem_read_arbiter.sv
// Two-port (I/D) read arbiter in front of one variable-latency read-only memory.
// Optional `ARB_ROUND_ROBIN_EN` selects round-robin arbitration instead of fixed D>I priority.
module mem_read_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  input  logic [31:0] mem_data,
  input  logic        mem_dvalid,
  output logic        busy,
  output logic        owner
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic        i_err_q, i_err_d;
  logic        d_valid_q, d_valid_d;
  logic        d_err_q, d_err_d;
  logic        pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q: port granted most recently, 0 = I, 1 = D
  logic last_q, last_d;

  assign pick_d = d_req && (!i_req || !last_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_valid_d  = 1'b0;
    i_err_d    = 1'b0;
    d_valid_d  = 1'b0;
    d_err_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (i_req || d_req) begin
          state_d    = StGrant;
          owner_d    = pick_d;
          mem_addr_d = pick_d ? d_addr : i_addr;
          cnt_d      = 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d     = pick_d;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (mem_dvalid) begin
          state_d = StDone;
          if (owner_q) begin
            d_rdata_d = mem_data;
            d_valid_d = 1'b1;
          end else begin
            i_rdata_d = mem_data;
            i_valid_d = 1'b1;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StDone;
          if (owner_q) begin
            d_rdata_d = ERR_DATA;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            i_rdata_d = ERR_DATA;
            i_valid_d = 1'b1;
            i_err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mem_addr_q <= 32'h0;
      owner_q    <= 1'b0;
      cnt_q      <= 16'd0;
      i_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
      i_valid_q  <= 1'b0;
      i_err_q    <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_valid_q  <= i_valid_d;
      i_err_q    <= i_err_d;
      d_valid_q  <= d_valid_d;
      d_err_q    <= d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Strobe drops in the same cycle the memory presents data.
  assign mem_read_en = (state_q == StGrant) && !mem_dvalid;
  assign busy        = (state_q == StGrant);
  assign mem_addr    = mem_addr_q;
  assign owner       = owner_q;
  assign i_rdata     = i_rdata_q;
  assign i_valid     = i_valid_q;
  assign i_err       = i_err_q;
  assign d_rdata     = d_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_err       = d_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter with a behavioural delay-1 memory model.
// Round-robin expectations apply when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_read_arbiter;

  localparam int unsigned Timeout  = 8;
  localparam int          MemDelay = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [31:0] i_rdata, d_rdata;
  logic        i_valid, i_err, d_valid, d_err;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic [31:0] mem_data;
  logic        mem_dvalid;
  logic        busy, owner;
  logic        mem_stall;
  int          mem_cnt;

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .TIMEOUT_CYCLES(Timeout),
    .ERR_DATA      (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_err      (d_err),
    .mem_addr   (mem_addr),
    .mem_read_en(mem_read_en),
    .mem_data   (mem_data),
    .mem_dvalid (mem_dvalid),
    .busy       (busy),
    .owner      (owner)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h1234_5678;
      32'h20:  return 32'hCAFE_F00D;
      32'h00:  return 32'h1111_0000;
      32'h04:  return 32'h2222_0004;
      32'h08:  return 32'h3333_0008;
      default: return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory: dvalid rises MemDelay+1 edges after the strobe first appears.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_dvalid <= 1'b0;
      mem_data   <= 32'h0;
      mem_cnt    <= 0;
    end else if (mem_dvalid) begin
      mem_dvalid <= 1'b0;
      mem_cnt    <= 0;
    end else if (mem_read_en && !mem_stall) begin
      if (mem_cnt == MemDelay) begin
        mem_dvalid <= 1'b1;
        mem_data   <= mem_word(mem_addr);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic push_exp(input logic port, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every response pulse is matched against the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (i_valid || d_valid) begin
      check("both_valid", 32'(i_valid & d_valid), 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'({i_valid, d_valid}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 32'(d_valid), 32'(e.port));
        check("resp_err", 32'(d_valid ? d_err : i_err), 32'(e.err));
        check("resp_data", d_valid ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_ctrl"}, 32'({mem_read_en, busy, owner, i_valid, i_err, d_valid, d_err}),
          32'h0);
    check({tag, "_i_rdata"}, i_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic wait_valid(input int budget, output logic got_d);
    got_d = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (i_valid || d_valid) begin
        got_d = d_valid;
        return;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL wait_valid: no response within %0d cycles", budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gd;
    int   lat, ren, gc, idle, grants, nresp, nv;
    logic prev_busy;
    logic exp_ports[4];

    reset_n   = 1'b0;
    i_req     = 1'b0;
    d_req     = 1'b0;
    i_addr    = 32'h0;
    d_addr    = 32'h0;
    mem_stall = 1'b0;
    step();
    step();
    check_reset_state("rst");
    reset_n = 1'b1;
    step();

    // Single I read at 0x10.
    i_req  = 1'b1;
    i_addr = 32'h10;
    push_exp(1'b0, 32'h1234_5678, 1'b0);
    lat = 0;
    ren = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (mem_read_en) ren++;
      if (i_valid) begin
        lat = k - 1;
        break;
      end
    end
    check("t1_latency_edges", 32'(lat), 32'd3);
    check("t1_read_en_cycles", 32'(ren), 32'd2);
    i_req = 1'b0;
    step();

    // Simultaneous I and D: D first, then I.
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h10;
    d_req  = 1'b1;
    d_addr = 32'h20;
    push_exp(1'b1, 32'hCAFE_F00D, 1'b0);
    push_exp(1'b0, 32'h1234_5678, 1'b0);
    wait_valid(20, gd);
    check("t2_first_port", 32'(gd), 32'd1);
    check("t2_first_owner", 32'(owner), 32'd1);
    d_req = 1'b0;
    wait_valid(20, gd);
    check("t2_second_port", 32'(gd), 32'd0);
    check("t2_second_owner", 32'(owner), 32'd0);
    check("t2_d_rdata_held", d_rdata, 32'hCAFE_F00D);
    i_req = 1'b0;
    step();

    // Both held for four reads.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ports = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ports = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    i_req = 1'b1;
    d_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      push_exp(exp_ports[n], exp_ports[n] ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      wait_valid(20, gd);
      check($sformatf("t3_grant%0d_port", n), 32'(gd), 32'(exp_ports[n]));
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // D back-to-back at 0x0, 0x4, 0x8.
    d_req  = 1'b1;
    d_addr = 32'h0;
    push_exp(1'b1, 32'h1111_0000, 1'b0);
    push_exp(1'b1, 32'h2222_0004, 1'b0);
    push_exp(1'b1, 32'h3333_0008, 1'b0);
    idle      = 0;
    grants    = 0;
    nresp     = 0;
    prev_busy = busy;
    for (int k = 0; k < 40; k++) begin
      step();
      if (busy && !prev_busy) grants++;
      prev_busy = busy;
      if (d_valid) nresp++;
      if (nresp >= 1 && !busy) idle++;
      if (d_valid) begin
        if (nresp == 1) d_addr = 32'h4;
        else if (nresp == 2) d_addr = 32'h8;
        else begin
          d_req = 1'b0;
          break;
        end
      end
    end
    check("t4_responses", 32'(nresp), 32'd3);
    check("t4_mem_reads", 32'(grants), 32'd3);
    check("t4_nonbusy_cycles", 32'(idle), 32'd3);
    step();
    step();
    check("t4_no_extra_read", 32'(busy), 32'd0);

    // Timeout: memory never answers.
    mem_stall = 1'b1;
    d_req     = 1'b1;
    d_addr    = 32'h40;
    push_exp(1'b1, 32'h0000_0000, 1'b1);
    gc = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (busy) gc++;
      if (d_valid) break;
    end
    check("t5_grant_cycles", 32'(gc), 32'd8);
    check("t5_read_en_done", 32'(mem_read_en), 32'd0);
    d_req = 1'b0;
    step();
    check("t5_read_en_after", 32'(mem_read_en), 32'd0);
    mem_stall = 1'b0;
    step();

    // Reset in the middle of GRANT.
    i_req  = 1'b1;
    i_addr = 32'h10;
    step();
    step();
    check("t6_in_grant", 32'(busy), 32'd1);
    reset_n = 1'b0;
    i_req   = 1'b0;
    step();
    check_reset_state("t6_rst");
    reset_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (i_valid || d_valid || mem_read_en) nv++;
    end
    check("t6_quiet_after_reset", 32'(nv), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-port read arbiter sharing one single-port, read-only, variable-latency memory between the CPU instruction-fetch port (I) and data-load port (D). It sequences one outstanding memory read at a time and holds `mem_read_en` until `mem_dvalid`. It returns the word to the winning requester with a one-cycle valid pulse. A timeout guards against a memory that never responds.

## Interface
- `TIMEOUT_CYCLES`, 64: GRANT cycles without `mem_dvalid` before the read is aborted with error; legal range 2..65535.
- `ERR_DATA`, 32'h0000_0000: value driven on `*_rdata` with an error response.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `i_req`  in  1  I-port read request; hold high with `i_addr` stable until `i_valid`.
- `i_addr`  in  32  I-port byte address.
- `i_rdata`  out  32  I-port read data, valid while `i_valid`.
- `i_valid`  out  1  one-cycle response pulse.
- `i_err`  out  1  qualifies `i_valid`: response is a timeout.
- `d_req`, `d_addr`, `d_rdata`, `d_valid`, `d_err`: D-port equivalents, same widths and rules.
- `mem_addr`  out  32  address to memory.
- `mem_read_en`  out  1  memory read strobe.
- `mem_data`  in  32  memory read data.
- `mem_dvalid`  in  1  memory data valid.
- `busy`  out  1  high in GRANT.
- `owner`  out  1  current/last grant: 0 = I, 1 = D.

## Operation
- States: IDLE, GRANT, DONE. Reset → IDLE.
- IDLE/DONE: if any `*_req`, pick a winner, latch its address into `mem_addr`, set `owner`, clear the timeout counter, and go to GRANT. Otherwise go to IDLE.
- Arbitration without macro: fixed priority, D over I.
- GRANT: `mem_read_en = !mem_dvalid`, combinational on the registered state. The strobe drops in the same cycle memory presents data, so memory never sees a held strobe after completion. `*_req` inputs are ignored.
- GRANT and `mem_dvalid`=1: capture `mem_data` into the owner's `*_rdata`, then go to DONE.
- GRANT, no `mem_dvalid`, counter == TIMEOUT_CYCLES-1: drive ERR_DATA and assert `*_err`, then go to DONE. `mem_read_en` is 0 in DONE.
- Counter increments each GRANT cycle. It is 16 bits and never wraps because of the parameter range.
- DONE: owner's `*_valid`=1 (plus `*_err` if timed out) for exactly one cycle. The requester drops `*_req` at the edge ending DONE, or keeps it high with a new address to issue a back-to-back read. The arbiter samples reqs at that edge exactly as in IDLE.
- Non-owner port: its `*_valid` and `*_err` are 0 and its `*_rdata` holds its last value.
- Request dropped during GRANT: protocol violation. The read still completes and the valid pulse is still issued.

## Timing
- Reset values: state IDLE, `mem_read_en`=0, `mem_addr`=0, `busy`=0, `owner`=0, all `*_valid`/`*_err`=0, all `*_rdata`=0, counter 0, last-grant = I.
- Synchronous reset asserted mid-GRANT: next edge goes to IDLE, `mem_read_en`=0 and no valid pulse is issued. The memory is reset together with the arbiter.
- Latency: req sampled at edge E; memory with delay D raises dvalid after edge E+D+1; valid is high in the cycle after edge E+D+2. For D=1 this is 3 edges.
- Throughput: one read per D+2 cycles on back-to-back requests; no idle bubble.
- Simultaneous I and D reqs: one grant, and the loser waits with its request held.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: two-way round-robin on a last-grant register. On a tie the port not granted last wins; a lone requester always wins. Last-grant updates on every grant.
- Undefined: fixed D>I priority, and the last-grant register is not built.

## Test plan
- Memory D=1, word 0x10 = 0x12345678; I reads 0x10 alone → `i_valid` 3 edges after the sampling edge, `i_rdata`=0x12345678, `i_err`=0, `mem_read_en` high exactly 2 cycles.
- I at 0x10 and D at 0x20 (=0xCAFEF00D) raised in the same cycle, macro off → D served first, then I; `owner` goes 1 then 0; both values correct.
- Same stimulus with `ARB_ROUND_ROBIN_EN`, both held for 4 reads → grants alternate D, I, D, I (last-grant=I after reset).
- D holds req with a new address after each `d_valid` (0x0, 0x4, 0x8) → three responses at a 3-cycle spacing, with no duplicate memory read.
- Memory `mem_dvalid` tied low, TIMEOUT_CYCLES=8 → `d_valid`=1, `d_err`=1, `d_rdata`=0 after 8 GRANT cycles; `mem_read_en` low afterwards.
- `reset_n`=0 for one edge in mid-GRANT → all outputs return to their reset values, and no valid pulse is issued afterwards without a new req.
